// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - two-entry skid-buffered pipeline stage with flush and bubble insertion
// Optional backpressure counter: define PIPE_STAGE_STALL_CNT_EN.
module pipe_skid_stage #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [31:0]       stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
  logic [DATA_W-1:0] main_data_q, skid_data_q;
  logic              in_ready_q, out_valid_q;
  logic [1:0]        occ_q;

  logic              in_ready_d, out_valid_d;
  logic [1:0]        occ_d;
  logic              in_fire, out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  // State and handshake flags are all registered so in_ready never sees out_ready combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      occ_q       <= occ_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (in_fire) state_d = ST_BUSY;
      ST_BUSY: begin
        if (out_fire && !in_fire)      state_d = ST_EMPTY;
        else if (!out_fire && in_fire) state_d = ST_FULL;
      end
      ST_FULL:  if (out_fire) state_d = ST_BUSY;
      default:  state_d = ST_EMPTY;
    endcase
    if (flush) state_d = ST_EMPTY;
  end

  always_comb begin
    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d != ST_EMPTY);
    case (state_d)
      ST_BUSY: occ_d = 2'd1;
      ST_FULL: occ_d = 2'd2;
      default: occ_d = 2'd0;
    endcase
    in_ready  = in_ready_q;
    out_valid = out_valid_q;
    occupancy = occ_q;
    out_ctrl  = main_ctrl_q;
    out_data  = main_data_q;
  end

  // Control is zeroed whenever the head goes empty so a bubble reads as NOP downstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else if (flush) begin
      main_ctrl_q <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_ctrl_q <= in_ctrl;
            main_data_q <= in_data;
          end
        end
        ST_BUSY: begin
          if (in_fire && out_fire) begin
            main_ctrl_q <= in_ctrl;
            main_data_q <= in_data;
          end else if (out_fire) begin
            main_ctrl_q <= '0;
          end else if (in_fire) begin
            skid_ctrl_q <= in_ctrl;
            skid_data_q <= in_data;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            main_ctrl_q <= skid_ctrl_q;
            main_data_q <= skid_data_q;
          end
        end
        default: main_ctrl_q <= '0;
      endcase
    end
  end

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'h0;
    end else if (out_valid_q && !out_ready && !flush && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb/tb_pipe_skid_stage.sv - scoreboard bench for pipe_skid_stage
// Directed vectors; a negedge monitor pops expected entries on every out_fire.
module tb_pipe_skid_stage;

  localparam int CTRL_W = 16;
  localparam int DATA_W = 128;

  typedef struct {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [31:0]       stall_cnt;

  entry_t exp_q[$];
  int     errors = 0;
  int     checks = 0;

  pipe_skid_stage #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                       input logic expect_accept);
    entry_t e;
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
    if (v && expect_accept) begin
      e.ctrl = c;
      e.data = d;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: every head handed downstream must be the oldest expected entry.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {{(DATA_W-CTRL_W){1'b0}}, out_ctrl}, '1);
      end else begin
        entry_t e;
        e = exp_q.pop_front();
        chk("out_ctrl_order", {{(DATA_W-CTRL_W){1'b0}}, out_ctrl}, {{(DATA_W-CTRL_W){1'b0}}, e.ctrl});
        chk("out_data_order", out_data, e.data);
      end
    end
    if (!reset && !out_valid)
      chk("bubble_ctrl_zero", {{(DATA_W-CTRL_W){1'b0}}, out_ctrl}, '0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset then idle
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_stall_cnt", stall_cnt, 0);

    // Streaming back-to-back
    out_ready = 1'b1;
    drive(1, 16'h0011, 128'hA, 1);
    tick();
    chk("stream1_valid", out_valid, 1);
    chk("stream1_occ", occupancy, 1);
    chk("stream1_in_ready", in_ready, 1);
    drive(1, 16'h0022, 128'hB, 1);
    tick();
    chk("stream2_ctrl", out_ctrl, 16'h0022);
    chk("stream2_occ", occupancy, 1);
    chk("stream2_in_ready", in_ready, 1);
    drive(0, '0, '0, 0);
    tick();
    chk("stream_drain_valid", out_valid, 0);
    chk("stream_drain_ctrl", out_ctrl, 0);

    // Skid fill under backpressure
    out_ready = 1'b0;
    drive(1, 16'h0101, 128'h1, 1);
    tick();
    chk("skid1_in_ready", in_ready, 1);
    drive(1, 16'h0202, 128'h2, 1);
    tick();
    chk("skid2_occ", occupancy, 2);
    chk("skid2_in_ready", in_ready, 0);
    drive(1, 16'h0303, 128'h3, 0);
    tick();
    chk("skid3_occ", occupancy, 2);
    chk("skid3_hold_ctrl", out_ctrl, 16'h0101);
    chk("skid3_hold_data", out_data, 128'h1);
    drive(0, '0, '0, 0);
    out_ready = 1'b1;
    tick();
    chk("skid_pop_ctrl", out_ctrl, 16'h0202);
    chk("skid_pop_in_ready", in_ready, 1);
    tick();
    chk("skid_empty_valid", out_valid, 0);
    chk("skid_empty_ctrl", out_ctrl, 0);
    chk("skid_queue_empty", exp_q.size(), 0);

    // Flush while FULL, with a simultaneous push that must vanish
    out_ready = 1'b0;
    drive(1, 16'h0505, 128'h5, 1);
    tick();
    drive(1, 16'h0606, 128'h6, 1);
    tick();
    chk("pre_flush_occ", occupancy, 2);
    flush = 1'b1;
    drive(1, 16'h0404, 128'h4, 0);
    tick();
    flush = 1'b0;
    drive(0, '0, '0, 0);
    exp_q.delete();
    chk("flush_occ", occupancy, 0);
    chk("flush_valid", out_valid, 0);
    chk("flush_ctrl", out_ctrl, 0);
    chk("flush_in_ready", in_ready, 1);
    chk("flush_data_held", out_data, 128'h5);
    out_ready = 1'b1;
    tick();
    tick();
    chk("flush_no_leak", out_valid, 0);

    // Reset mid-operation overrides flush and handshakes
    out_ready = 1'b0;
    drive(1, 16'h0707, 128'h7, 1);
    tick();
    drive(1, 16'h0808, 128'h8, 1);
    tick();
    reset = 1'b1;
    flush = 1'b1;
    drive(1, 16'h0909, 128'h9, 0);
    tick();
    reset = 1'b0;
    flush = 1'b0;
    drive(0, '0, '0, 0);
    exp_q.delete();
    chk("mrst_valid", out_valid, 0);
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_occ", occupancy, 0);
    chk("mrst_ctrl", out_ctrl, 0);
    chk("mrst_data", out_data, 0);
    chk("mrst_stall", stall_cnt, 0);
    out_ready = 1'b1;
    drive(1, 16'h0A0A, 128'hDEAD_BEEF, 1);
    tick();
    chk("post_rst_ctrl", out_ctrl, 16'h0A0A);
    drive(1, 16'h0B0B, 128'hCAFE, 1);
    tick();
    drive(0, '0, '0, 0);
    tick();
    chk("post_rst_drained", out_valid, 0);

`ifdef PIPE_STAGE_STALL_CNT_EN
    out_ready = 1'b0;
    drive(1, 16'h0C0C, 128'hC, 1);
    tick();
    drive(0, '0, '0, 0);
    for (int i = 0; i < 5; i++) tick();
    chk("stall_cnt_5", stall_cnt, 5);
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    for (int i = 0; i < 3; i++) tick();
    chk("stall_cnt_sat", stall_cnt, 32'hFFFF_FFFF);
    out_ready = 1'b1;
    tick();
    tick();
`else
    out_ready = 1'b0;
    drive(1, 16'h0C0C, 128'hC, 1);
    tick();
    drive(0, '0, '0, 0);
    for (int i = 0; i < 5; i++) tick();
    chk("stall_cnt_off", stall_cnt, 0);
    out_ready = 1'b1;
    tick();
    tick();
`endif
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_occ", occupancy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
